// File: rtl/fifo_pace_pkg.sv
// Shared types and reset defaults for the FIFO pacing controller.
package fifo_pace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_PERIOD = 125000000;
    localparam int unsigned DEFAULT_BURST  = 4;

endpackage

// File: rtl/fifo_pace_ctrl_timebase.sv
// pace_timebase: period counter with a registered one-cycle tick.
// wrap is high on the edge that produces the next tick.
module pace_timebase #(
    parameter int unsigned PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                wrap,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;

    // Periods 0 and 1 both mean a tick on every cycle.
    assign wrap = en && ((period <= PERIOD_W'(1)) ||
                         (cnt == period - PERIOD_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (!en || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_pace_ctrl.sv
// fifo_pace_ctrl: alternates paced FIFO write and read bursts in the clk domain.
// Define FIFO_PACE_SLOW_CLK_EN to drive slow_clk as a tick-rate square wave.
module fifo_pace_ctrl
    import fifo_pace_pkg::*;
#(
    parameter int unsigned PERIOD_W       = 32,
    parameter int unsigned BURST_W        = 8,
    parameter int unsigned DEFAULT_PERIOD = fifo_pace_pkg::DEFAULT_PERIOD,
    parameter int unsigned DEFAULT_BURST  = fifo_pace_pkg::DEFAULT_BURST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [BURST_W-1:0]  cfg_burst,
    input  logic                start,
    input  logic                stop,
    input  logic                fifo_full,
    input  logic                fifo_empty,
    output logic                wr_en,
    output logic                rd_en,
    output logic                tick,
    output logic                busy,
    output logic [1:0]          state_o,
    output logic                slow_clk
);

    state_e              state;
    logic [PERIOD_W-1:0] period_r;
    logic [BURST_W-1:0]  burst_r;
    logic [BURST_W-1:0]  bcnt;
    logic [BURST_W-1:0]  burst_eff;
    logic                stop_pend;
    logic                wrap;
    logic                last_op;

    assign busy      = (state != IDLE);
    assign cfg_ready = (state == IDLE);
    assign state_o   = state;
    assign burst_eff = (burst_r == '0) ? BURST_W'(1) : burst_r;
    assign last_op   = (bcnt + BURST_W'(1) == burst_eff);

    pace_timebase #(
        .PERIOD_W (PERIOD_W)
    ) u_timebase (
        .clk    (clk),
        .rst    (rst),
        .en     (busy),
        .period (period_r),
        .wrap   (wrap),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            period_r  <= PERIOD_W'(DEFAULT_PERIOD);
            burst_r   <= BURST_W'(DEFAULT_BURST);
            bcnt      <= '0;
            stop_pend <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        period_r <= cfg_period;
                        burst_r  <= cfg_burst;
                    end
                    if (start) begin
                        state <= WRITE;
                        bcnt  <= '0;
                    end
                end
                WRITE: begin
                    if (stop) stop_pend <= 1'b1;
                    if (wrap) begin
                        wr_en <= !fifo_full;
                        if (fifo_full || last_op) begin
                            state <= READ;
                            bcnt  <= '0;
                        end else begin
                            bcnt <= bcnt + BURST_W'(1);
                        end
                    end
                end
                READ: begin
                    if (stop) stop_pend <= 1'b1;
                    if (wrap) begin
                        rd_en <= !fifo_empty;
                        if (fifo_empty || last_op) begin
                            bcnt <= '0;
                            // A stop seen on this very edge waits for the next read end.
                            if (stop_pend) begin
                                state     <= IDLE;
                                stop_pend <= 1'b0;
                            end else begin
                                state <= WRITE;
                            end
                        end else begin
                            bcnt <= bcnt + BURST_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_PACE_SLOW_CLK_EN
    logic slow_q;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            slow_q <= 1'b0;
        end else if (wrap) begin
            slow_q <= ~slow_q;
        end
    end

    assign slow_clk = slow_q;
`else
    assign slow_clk = 1'b0;
`endif

endmodule
